// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/ack handshake for the two RAM requesters (A = fetch, B = data tape).
interface ram_arbiter_if #(
    parameter int AddressSize = 16,
    parameter int DataSize    = 8
);
    logic                   a_req;
    logic                   a_we;
    logic [AddressSize-1:0] a_addr;
    logic [DataSize-1:0]    a_wdata;
    logic                   a_ack;
    logic [DataSize-1:0]    a_rdata;
    logic                   b_req;
    logic                   b_we;
    logic [AddressSize-1:0] b_addr;
    logic [DataSize-1:0]    b_wdata;
    logic                   b_ack;
    logic [DataSize-1:0]    b_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
        output a_ack, a_rdata, b_ack, b_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata,
        input  a_ack, a_rdata, b_ack, b_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port controller for the shared synchronous RAM.
// Fixed IDLE -> ACCESS -> DONE sequence; DONE doubles as the data-bus turnaround.
module ram_arbiter #(
    parameter int AddressSize = 16,
    parameter int DataSize    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram_arbiter_if.slave           req_if,
    output logic                   busy_o,
    output logic [AddressSize-1:0] ram_address_o,
    output logic                   ram_cs_o,
    output logic                   ram_we_n_o,
    inout  wire  [DataSize-1:0]    ram_data_io
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state_q;
    logic                   last_b_q;
    logic                   win_b_q;
    logic                   we_q;
    logic                   drive_q;
    logic                   cs_q;
    logic                   we_n_q;
    logic                   a_ack_q;
    logic                   b_ack_q;
    logic [AddressSize-1:0] addr_q;
    logic [DataSize-1:0]    wdata_q;
    logic [DataSize-1:0]    a_rdata_q;
    logic [DataSize-1:0]    b_rdata_q;
    logic                   grant_b_d;

    // B wins when alone, or on a tie when A was granted last
    always_comb grant_b_d = req_if.b_req && (!req_if.a_req || !last_b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            win_b_q   <= 1'b0;
            we_q      <= 1'b0;
            drive_q   <= 1'b0;
            cs_q      <= 1'b0;
            we_n_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_if.a_req || req_if.b_req) begin
                    state_q  <= ACCESS;
                    win_b_q  <= grant_b_d;
                    last_b_q <= grant_b_d;
                    we_q     <= grant_b_d ? req_if.b_we : req_if.a_we;
                    addr_q   <= grant_b_d ? req_if.b_addr : req_if.a_addr;
                    wdata_q  <= grant_b_d ? req_if.b_wdata : req_if.a_wdata;
                    cs_q     <= 1'b1;
                    we_n_q   <= !(grant_b_d ? req_if.b_we : req_if.a_we);
                    drive_q  <= grant_b_d ? req_if.b_we : req_if.a_we;
                end
                ACCESS: begin
                    state_q <= DONE;
                    cs_q    <= 1'b0;
                    we_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                    a_ack_q <= !win_b_q;
                    b_ack_q <= win_b_q;
                    if (!we_q && win_b_q) b_rdata_q <= ram_data_io;
                    if (!we_q && !win_b_q) a_rdata_q <= ram_data_io;
                end
                DONE: begin
                    state_q <= IDLE;
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o         = state_q != IDLE;
    assign ram_address_o  = addr_q;
    assign ram_cs_o       = cs_q;
    assign ram_we_n_o     = we_n_q;
    assign ram_data_io    = drive_q ? wdata_q : 'z;
    assign req_if.a_ack   = a_ack_q;
    assign req_if.b_ack   = b_ack_q;
    assign req_if.a_rdata = a_rdata_q;
    assign req_if.b_rdata = b_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed + random requests checked cycle-by-cycle against a transaction-level model.
module tb_ram_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AddressSize(AW), .DataSize(DW)) bus_if ();
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_cs;
    logic          ram_we_n;
    tri1  [DW-1:0] ram_data;

    ram_arbiter #(.AddressSize(AW), .DataSize(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_if(bus_if.slave), .busy_o(busy),
        .ram_address_o(ram_addr), .ram_cs_o(ram_cs), .ram_we_n_o(ram_we_n), .ram_data_io(ram_data)
    );

    // synchronous RAM: drives only on CS && WE_n, commits writes at posedge
    logic [DW-1:0] ram_mem [0:65535];
    assign ram_data = (ram_cs && ram_we_n) ? ram_mem[ram_addr] : 'z;
    always @(posedge clk) if (ram_cs && !ram_we_n) ram_mem[ram_addr] <= ram_data;

    int total = 0;
    int bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // model: an access granted at edge g occupies edges g..g+2; next grant no earlier than g+3
    logic [DW-1:0] ref_mem [0:65535];
    int            cyc = 0;
    int            g = -10;
    bit            win_b = 1'b0;
    bit            last_b = 1'b1;
    bit            pend = 1'b0;
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] exp_ra = '0;
    logic [DW-1:0] exp_rb = '0;
    bit            out_a = 1'b0;
    bit            out_b = 1'b0;
    int            a_ack_cyc = -1;
    int            b_ack_cyc = -1;
    int            acks[$];

    task automatic step();
        cyc++;
        if (pend && cyc == g + 1) begin
            if (m_we) ref_mem[m_addr] = m_wd;
            else if (win_b) exp_rb = ref_mem[m_addr];
            else exp_ra = ref_mem[m_addr];
            pend = 1'b0;
        end
        if (cyc - g >= 3 && (bus_if.a_req || bus_if.b_req)) begin
            win_b  = bus_if.b_req && (!bus_if.a_req || !last_b);
            last_b = win_b;
            g      = cyc;
            pend   = 1'b1;
            m_we   = win_b ? bus_if.b_we : bus_if.a_we;
            m_addr = win_b ? bus_if.b_addr : bus_if.a_addr;
            m_wd   = win_b ? bus_if.b_wdata : bus_if.a_wdata;
        end
    endtask

    task automatic check();
        int d = cyc - g;
        logic [DW-1:0] exp_bus = (d == 0) ? (m_we ? m_wd : ref_mem[m_addr]) : 8'hFF;
        chk("cs", 32'(ram_cs), 32'(d == 0));
        chk("we_n", 32'(ram_we_n), 32'(!(d == 0 && m_we)));
        if (d == 0) chk("addr", 32'(ram_addr), 32'(m_addr));
        chk("bus", 32'(ram_data), 32'(exp_bus));
        chk("a_ack", 32'(bus_if.a_ack), 32'(d == 1 && !win_b));
        chk("b_ack", 32'(bus_if.b_ack), 32'(d == 1 && win_b));
        chk("busy", 32'(busy), 32'(d == 0 || d == 1));
        chk("a_rdata", 32'(bus_if.a_rdata), 32'(exp_ra));
        chk("b_rdata", 32'(bus_if.b_rdata), 32'(exp_rb));
        if (bus_if.a_ack) begin a_ack_cyc = cyc; acks.push_back(0); end
        if (bus_if.b_ack) begin b_ack_cyc = cyc; acks.push_back(1); end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) step();
        #1 check();
        if (cyc - g == 1 && rst_n) begin
            if (win_b) begin out_b = 1'b0; bus_if.b_req = 1'b0; end
            else begin out_a = 1'b0; bus_if.a_req = 1'b0; end
        end
    endtask

    task automatic issue(bit p, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd);
        if (p) begin
            bus_if.b_req = 1'b1; bus_if.b_we = we; bus_if.b_addr = addr; bus_if.b_wdata = wd; out_b = 1'b1;
        end else begin
            bus_if.a_req = 1'b1; bus_if.a_we = we; bus_if.a_addr = addr; bus_if.a_wdata = wd; out_a = 1'b1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (out_a || out_b); i++) cycle();
        chk("drain", 32'(out_a || out_b), 32'd0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk("rst_cs", 32'(ram_cs), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        g = cyc - 10; pend = 1'b0; last_b = 1'b1; exp_ra = '0; exp_rb = '0;
        out_a = 1'b0; out_b = 1'b0; bus_if.a_req = 1'b0; bus_if.b_req = 1'b0;
        cycle();
        cycle();
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'hFFFF;
            3: return 16'h1234;
            4: return 16'h0040;
            default: return 16'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        for (int i = 0; i < 65536; i++) begin ram_mem[i] = '0; ref_mem[i] = '0; end
        bus_if.a_req = 0; bus_if.a_we = 0; bus_if.a_addr = 0; bus_if.a_wdata = 0;
        bus_if.b_req = 0; bus_if.b_we = 0; bus_if.b_addr = 0; bus_if.b_wdata = 0;
        // reset with A_Req held, then A write 0x5A @0x1234 and read it back
        issue(0, 1, 16'h1234, 8'h5A);
        cycle();
        chk("rst_addr", 32'(ram_addr), 32'd0);
        cycle();
        #2 rst_n = 1'b1;
        cycle();
        chk("t1_cs", 32'(ram_cs), 32'd1);
        cycle();
        chk("t1_ack", 32'(bus_if.a_ack), 32'd1);
        issue(0, 0, 16'h1234, 8'h00);
        drain();
        chk("a_rd_5a", 32'(bus_if.a_rdata), 32'h5A);
        chk("b_never", 32'(b_ack_cyc), 32'hFFFF_FFFF);
        // both held from reset: strict A,B,A,B
        do_reset();
        n0 = acks.size();
        issue(0, 0, 16'h0001, 8'h00);
        issue(1, 1, 16'h0002, 8'hC3);
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (!out_a) issue(0, 0, 16'h0001, 8'h00);
            if (!out_b) issue(1, 1, 16'h0002, 8'hC3);
        end
        drain();
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(acks[n0 + i]), 32'(i % 2));
        // B write/read at top address, A reads pre-written 0x0000
        issue(0, 1, 16'h0000, 8'h11);
        drain();
        issue(1, 1, 16'hFFFF, 8'hFF);
        drain();
        chk("b_wr_keep", 32'(bus_if.b_rdata), 32'd0);
        issue(1, 0, 16'hFFFF, 8'h00);
        issue(0, 0, 16'h0000, 8'h00);
        drain();
        chk("b_rd_ff", 32'(bus_if.b_rdata), 32'hFF);
        chk("a_rd_11", 32'(bus_if.a_rdata), 32'h11);
        // reset during a B write ACCESS aborts it
        issue(0, 1, 16'h0040, 8'h3C);
        drain();
        issue(1, 1, 16'h0040, 8'h77);
        for (int i = 0; i < 6 && g != cyc; i++) cycle();
        chk("abort_grant", 32'(ram_cs), 32'd1);
        do_reset();
        issue(1, 0, 16'h0040, 8'h00);
        drain();
        chk("abort_old", 32'(bus_if.b_rdata), 32'h3C);
        // B raised during A's DONE is acked exactly 3 cycles after A
        issue(0, 0, 16'h1234, 8'h00);
        for (int i = 0; i < 8 && cyc - g != 1; i++) cycle();
        issue(1, 0, 16'hFFFF, 8'h00);
        drain();
        chk("b_after_a", 32'(b_ack_cyc - a_ack_cyc), 32'd3);
        // random traffic with occasional early Req drop and reset
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (g == cyc && $urandom_range(0, 3) == 0) begin
                if (win_b) bus_if.b_req = 1'b0; else bus_if.a_req = 1'b0;
            end
            if (!out_a && $urandom_range(0, 2) == 0) issue(0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            if (!out_b && $urandom_range(0, 2) == 0) issue(1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester controller for the shared synchronous tape/program RAM: port A (instruction fetch) and port B (data tape) issue single-word read/write requests.
- Arbitrates round-robin and sequences the RAM's Address/CS/WE_n/Data pins, including the bidirectional data bus.
- Returns read data with a one-cycle ack pulse.
- Sits between the DPC core sequencer and the RAM instance.

Parameters:
AddressSize, 16, RAM address width
DataSize, 8, RAM word width

Ports:
Clk  input  1  system clock, all state on posedge
Rst_n  input  1  asynchronous active-low reset
A_Req  input  1  port A request, held high until A_Ack
A_We  input  1  port A: 1=write, 0=read
A_Addr  input  AddressSize  port A address
A_WData  input  DataSize  port A write data
A_Ack  output  1  port A one-cycle completion pulse
A_RData  output  DataSize  port A read data, valid with A_Ack and held until next A read completes
B_Req, B_We, B_Addr, B_WData, B_Ack, B_RData  same as port A, for port B
Busy  output  1  high whenever state != IDLE
Ram_Address  output  AddressSize  RAM address
Ram_CS  output  1  RAM chip select, active high
Ram_WE_n  output  1  RAM write enable, active low
Ram_Data  inout  DataSize  RAM data bus

Behaviour:
- Reset (Rst_n=0, asynchronous) forces the following, with no write committed while reset is asserted:
  - state=IDLE
  - Ram_CS=0, Ram_WE_n=1, Ram_Address=0, Ram_Data=Z
  - A_Ack=B_Ack=0, A_RData=B_RData=0, Busy=0
  - last-grant pointer=B, so A wins the first tie
- All RAM-side outputs are registered; no combinational path from requester inputs to RAM pins.
- States: IDLE -> ACCESS -> DONE -> IDLE. Fixed 3-cycle sequence, no waits.
- IDLE:
  - If any Req is high, select a winner: the only requester, or on a tie the one not last granted.
  - Latch the winner's Addr/We/WData into internal registers. Update the pointer.
  - Next state is ACCESS.
  - If no Req is high, stay in IDLE.
- ACCESS (1 cycle):
  - Ram_CS=1, Ram_Address=latched address, Ram_WE_n=!latched We.
  - Write: Ram_Data is driven with latched WData. The RAM commits at the closing posedge.
  - Read: Ram_Data=Z. At the closing posedge, Ram_Data is captured into the winner's RData.
  - Next state is DONE.
- DONE (1 cycle):
  - Ram_CS=0, Ram_WE_n=1, Ram_Data=Z.
  - Winner's Ack=1 for exactly this cycle. The loser's Ack stays 0.
  - Next state is IDLE. This cycle is the bus turnaround.
- Bus rule: the controller drives Ram_Data only in ACCESS with WE_n=0. The RAM drives Ram_Data only when CS=1 and WE_n=1. These rules guarantee no contention.
- Latency: Req sampled high in IDLE at edge N; ACCESS in N+1; Ack in N+2. Peak throughput is one access per 3 cycles.
- Requester rules:
  - Req must stay high with stable Addr/We/WData until Ack.
  - Req is sampled only in IDLE.
  - A requester dropping Req after being granted still completes its access and receives Ack.
  - A Req that rises in ACCESS or DONE waits until IDLE.
- Fairness: with both Req held continuously, grants strictly alternate A,B,A,B. Worst-case wait is 6 cycles.
- Write acks: RData is unchanged on a write ack. It changes only on that port's read completion.
- Address: wraps naturally at full width; no range checking.
- Reset mid-ACCESS: the access is aborted, no Ack is issued, and the request must be re-issued after reset.

Test Plan:
- Reset with A_Req=1 held -> all outputs at reset values; first Clk after Rst_n rises: IDLE grants A, Ram_CS=1 one cycle later, A_Ack two cycles later.
- A writes 0x5A to 0x1234, then A reads 0x1234 -> Ram_WE_n=0 and Ram_Data=0x5A only in the write ACCESS cycle; read A_Ack with A_RData=0x5A; B_Ack never pulses.
- A and B both request from reset (A read 0x0001, B write 0xC3 to 0x0002), Req held for 4 accesses -> grant order A,B,A,B; each Ack pulses exactly 1 cycle, 3 cycles apart; Ram_Data Z in all IDLE/DONE cycles.
- B writes 0xFF to 0xFFFF then reads 0xFFFF; A reads 0x0000 (pre-written 0x11) -> B_RData=0xFF, A_RData=0x11; B_RData unchanged after its write ack.
- Rst_n pulsed low during a B write ACCESS (before posedge) -> Ram_CS drops immediately; no B_Ack; a subsequent read of that address returns the old value.
- B_Req raised during A's DONE cycle -> B granted at next IDLE edge, B_Ack exactly 3 cycles after A_Ack.
